dm_responder: RTL
=================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the byte-address bits decoded; depth is 2^(ADDR_W-2) words.
REQ-002 Parameter WAIT_CYC, default 2, SHALL set wait states inserted per access (legal range 0..15).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  initiator (mips core) has a load/store request.
REQ-006 req_ready  out  1  responder can accept a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_be  in  4  byte enables for stores; bit i selects byte lane i.
REQ-010 req_wdata  in  32  store data, lane-aligned.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  initiator accepts the response.
REQ-013 resp_rdata  out  32  full load word; 0 for stores and errors.
REQ-014 resp_err  out  1  access error flag, valid with resp_valid.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on req_valid, SHALL capture we/addr/be/wdata and go to WAIT with counter=WAIT_CYC, or directly to RESP if WAIT_CYC=0.
REQ-017 WAIT: counter SHALL decrement each cycle; on the cycle it equals 1 the FSM SHALL go to RESP.
REQ-018 The transition into RESP SHALL commit the access: a store writes enabled lanes only; a load registers the addressed word into resp_rdata.
REQ-019 Latency: resp_valid SHALL first assert WAIT_CYC+1 cycles after the accepting edge.
REQ-020 RESP: resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1; the FSM then returns to IDLE, and no request is accepted on that same edge.
REQ-021 Error: req_addr[31:ADDR_W]!=0, req_addr[1:0]!=0, or a store with req_be=0 SHALL set resp_err=1, suppress the write, and force resp_rdata=0.
REQ-022 A load SHALL ignore req_be and return all 4 bytes.
REQ-023 Inputs are ignored outside IDLE; req_valid held high in WAIT/RESP SHALL NOT start a second access.
REQ-024 A load following a store to the same word SHALL return the merged post-store word.

Reset
REQ-025 Reset SHALL force state IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-026 Reset SHALL clear every memory word to 0.
REQ-027 Reset in WAIT SHALL discard the pending access; no write occurs. Reset in RESP SHALL drop the response. Reset dominates req_valid on the same edge.

Configuration
REQ-028 Macro DM_WAIT_EN defined: WAIT state and WAIT_CYC SHALL be honoured as above.
REQ-029 Macro DM_WAIT_EN undefined: WAIT state and counter SHALL be compiled out, WAIT_CYC ignored; IDLE goes directly to RESP, giving 1-cycle latency.

Structure
REQ-030 Shared package dm_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the byte-lane count (4) and the counter width (4).
REQ-031 Sub-module dm_wait_ctr (load, decrement, last-cycle flag) SHALL implement the wait counter and be instantiated only under DM_WAIT_EN.

Verification
REQ-032 WAIT_CYC=2: store addr 0x10, be=4'hF, data 0xDEADBEEF; then load 0x10 -> resp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-033 Store 0x10 be=4'b0010 data 0x00005500 over 0xDEADBEEF, then load -> rdata=0xDEAD55EF.
REQ-034 Load addr 0x2002 (misaligned) and 0x1000 (ADDR_W=12) -> err=1, rdata=0; a following load at 0x0 returns 0, memory unchanged.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-036 Store accepted, reset asserted in first WAIT cycle -> outputs at reset values next cycle; subsequent load returns 0.
REQ-037 Build without DM_WAIT_EN, WAIT_CYC=5: load -> resp_valid 1 cycle after accept.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the dm_responder data-memory slice.
//   state_t : responder FSM states (IDLE accepts, WAIT counts wait states,
//             RESP presents the response until the initiator takes it)
//   LANES   : byte lanes per 32-bit word
//   CNT_W   : width of the wait-state counter (wait states 0..15)
package dm_pkg;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_wait_ctr.sv
// Wait-state counter for dm_responder (present only in DM_WAIT_EN builds).
// Ports:
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : load load_val (takes priority over dec)
//   load_val   : number of wait states for the access being accepted
//   dec        : count down by one (stops at 0)
//   last       : high while the count equals 1, i.e. the final wait cycle
module dm_wait_ctr
  import dm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the mips core load/store port.
// One access at a time: IDLE accepts a request, optional WAIT inserts
// WAIT_CYC wait states, RESP holds the response until resp_ready.
// The access (store lane write or load read) commits on the edge that
// enters RESP. Bad addresses and empty-enable stores return resp_err=1,
// rdata 0 and leave memory untouched.
// Configuration macro: DM_WAIT_EN -- when defined, WAIT state and WAIT_CYC
// are honoured; when undefined, every access goes straight to RESP.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_we, req_addr      : store flag, byte address
//   req_be, req_wdata     : store byte enables, lane-aligned store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : load word (0 for stores/errors), error flag
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int IDX_W = ADDR_W - 2;

  state_t state, state_nxt;
  logic   commit;

  logic [31:0] mem [DEPTH];

  // Request fields as seen on the committing edge.
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [IDX_W-1:0] cur_idx;

  function automatic logic access_err(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [3:0]  be);
    return (addr[31:ADDR_W] != '0) || (addr[1:0] != 2'b00) ||
           (we && (be == 4'h0));
  endfunction

`ifdef DM_WAIT_EN
  localparam bit DIRECT_RESP = (WAIT_CYC == 0);

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        ctr_last;

  dm_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == IDLE) && req_valid && !DIRECT_RESP),
    .load_val (CNT_W'(WAIT_CYC)),
    .dec      (state == WAIT),
    .last     (ctr_last)
  );

  // Request is held here while wait states run; data only, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_be    <= req_be;
      cap_wdata <= req_wdata;
    end
  end

  // Zero-wait accesses commit straight from the live request inputs.
  assign cur_we    = (state == IDLE) ? req_we    : cap_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign cur_be    = (state == IDLE) ? req_be    : cap_be;
  assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
`else
  // WAIT_CYC has no effect in this build: every access goes straight to RESP.
  localparam bit DIRECT_RESP = 1'b1 | (WAIT_CYC == 0);

  assign cur_we    = req_we;
  assign cur_addr  = req_addr;
  assign cur_be    = req_be;
  assign cur_wdata = req_wdata;
`endif

  assign cur_err = access_err(cur_we, cur_addr, cur_be);
  assign cur_idx = cur_addr[ADDR_W-1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (DIRECT_RESP) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end
`ifdef DM_WAIT_EN
          else begin
            state_nxt = WAIT;
          end
`endif
        end
      end
`ifdef DM_WAIT_EN
      WAIT: begin
        if (ctr_last) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
`endif
      RESP: begin
        // Release returns to IDLE only; a new request waits for the next edge.
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= cur_err;
      resp_rdata <= (cur_err || cur_we) ? 32'h0 : mem[cur_idx];
      if (cur_we && !cur_err) begin
        for (int l = 0; l < LANES; l++) begin
          if (cur_be[l]) begin
            mem[cur_idx][8*l +: 8] <= cur_wdata[8*l +: 8];
          end
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule
